// File: rtl/oam_dma_engine.sv
// Sprite DMA: copies 256 bytes from page {P,00..FF} to the PPU OAM data port while stalling the CPU.
// Optional feature: define DMA_PARITY_EN to insert the extra get/put alignment cycle on odd parity.
module oam_dma_engine #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        stall,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_read,
  output logic        dma_write
);

  typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

  // Bus handshake: there is no back-pressure. Each READ cycle presents dma_addr with
  // dma_read=1 and captures bus_rdata on the edge ending it; each WRITE cycle presents
  // DEST_ADDR/dma_wdata with dma_write=1 for exactly one cycle.
  state_t     state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] data_q;
  logic [7:0] idx_nxt;

`ifdef DMA_PARITY_EN
  logic parity;
  logic align_second;
`endif

  assign idx_nxt   = idx + 8'd1;
  assign dma_wdata = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 8'd0;
      page       <= 8'd0;
      data_q     <= 8'd0;
      stall      <= 1'b0;
      dma_active <= 1'b0;
      dma_addr   <= 16'd0;
      dma_read   <= 1'b0;
      dma_write  <= 1'b0;
`ifdef DMA_PARITY_EN
      parity       <= 1'b0;
      align_second <= 1'b0;
`endif
    end else begin
`ifdef DMA_PARITY_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: begin
          if (cpu_write && cpu_addr == TRIGGER_ADDR) begin
            page       <= cpu_wdata;
            idx        <= 8'd0;
            state      <= ALIGN;
            stall      <= 1'b1;
            dma_active <= 1'b1;
`ifdef DMA_PARITY_EN
            align_second <= 1'b0;
`endif
          end
        end
        ALIGN: begin
`ifdef DMA_PARITY_EN
          // Odd parity in the first ALIGN cycle costs one more cycle before the first get.
          if (parity && !align_second) begin
            align_second <= 1'b1;
          end else begin
            state    <= READ;
            dma_addr <= {page, idx};
            dma_read <= 1'b1;
          end
`else
          state    <= READ;
          dma_addr <= {page, idx};
          dma_read <= 1'b1;
`endif
        end
        READ: begin
          data_q    <= bus_rdata;
          state     <= WRITE;
          dma_addr  <= DEST_ADDR;
          dma_read  <= 1'b0;
          dma_write <= 1'b1;
        end
        WRITE: begin
          dma_write <= 1'b0;
          if (idx == 8'hFF) begin
            // idx wraps inside the page; the source never carries into the next page.
            idx        <= 8'd0;
            state      <= IDLE;
            stall      <= 1'b0;
            dma_active <= 1'b0;
            dma_addr   <= 16'd0;
          end else begin
            idx      <= idx_nxt;
            state    <= READ;
            dma_addr <= {page, idx_nxt};
            dma_read <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: directed transfers, a memory model behind the bus and a scoreboard monitor.
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        stall;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_read;
  logic        dma_write;

  always #5 clk = ~clk;

  oam_dma_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_read   (dma_read),
    .dma_write  (dma_write)
  );

  // Memory model: page $02 holds i^$5A; other pages are offset so a wrong page shows up.
  logic [7:0] mem [65536];
  assign bus_rdata = mem[dma_addr];

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
  endfunction

  logic [23:0] exp_q [$];
  logic [15:0] rd_q [$];
  int          len_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  bit          abort_pending = 0;

  // Reference cycle parity, reset and toggled the same way the block's parity flop is.
  logic tb_par;
  always @(posedge clk) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event, value %h at %0t", name, act, $time);
  endtask

  // Monitor: samples on the falling edge and pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (dma_read && dma_write) flag("strobe_excl", {dma_addr, 8'h00});
    if (dma_active !== stall) check("active_eq_stall", {31'd0, dma_active}, {31'd0, stall});
    if (dma_read) begin
      if (rd_q.size() == 0) flag("unexp_read", {16'd0, dma_addr});
      else check("rd_addr", {16'd0, dma_addr}, {16'd0, rd_q.pop_front()});
    end
    if (dma_write) begin
      if (exp_q.size() == 0) flag("unexp_write", {8'd0, dma_addr, dma_wdata});
      else check("wr_addr_data", {8'd0, dma_addr, dma_wdata}, {8'd0, exp_q.pop_front()});
    end
    if (stall) begin
      stall_cnt++;
    end else if (stall_cnt > 0) begin
      if (abort_pending) abort_pending = 0;
      else if (len_q.size() == 0) flag("unexp_stall", stall_cnt);
      else check("stall_len", stall_cnt, len_q.pop_front());
      stall_cnt = 0;
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic wr);
    @(negedge clk); #1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = wr;
    @(posedge clk); #1;
    cpu_addr  = 16'd0;
    cpu_wdata = 8'd0;
    cpu_write = 1'b0;
  endtask

  // Queues the full expected transfer, then triggers it so the first ALIGN cycle has
  // parity want_odd.
  task automatic start_dma(input logic [7:0] page, input logic want_odd);
    int len;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] sa;
      sa = {page, i[7:0]};
      rd_q.push_back(sa);
      exp_q.push_back({16'h2004, src_byte(sa)});
    end
`ifdef DMA_PARITY_EN
    len = want_odd ? 514 : 513;
`else
    len = 513;
`endif
    len_q.push_back(len);
    @(negedge clk); #1;
    while ((~tb_par) != want_odd) begin
      @(negedge clk); #1;
    end
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    cpu_write = 1'b1;
    @(posedge clk); #1;
    cpu_addr  = 16'd0;
    cpu_wdata = 8'd0;
    cpu_write = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) flag({name, "_timeout"}, {31'd0, stall});
    check({name, "_queues_empty"}, exp_q.size() + rd_q.size() + len_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = src_byte(a[15:0]);
    rst       = 1'b1;
    cpu_addr  = 16'd0;
    cpu_write = 1'b0;
    cpu_wdata = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {28'd0, stall, dma_active, dma_read, dma_write}, 32'd0);
    check("reset_bus", {8'd0, dma_addr, dma_wdata}, 32'd0);
    #1 rst = 1'b0;

    // Page $02 from even parity: writes of i^$5A, 513-cycle stall.
    check("mem_model_0200", {24'd0, mem[16'h0200]}, 32'h5A);
    check("mem_model_02ff", {24'd0, mem[16'h02FF]}, 32'hA5);
    start_dma(8'h02, 1'b0);
    check("stall_rises", {31'd0, stall}, 32'd1);
    wait_done("t1_page02");

    // Odd parity in the first ALIGN cycle.
    start_dma(8'h02, 1'b1);
    wait_done("t2_odd");

    // Forced trigger of page $03 mid-transfer is ignored.
    start_dma(8'h02, 1'b0);
    repeat (10) @(negedge clk);
    cpu_cycle(16'h4014, 8'h03, 1'b1);
    check("t3_still_stalled", {31'd0, stall}, 32'd1);
    wait_done("t3_retrigger");

    // Reset during the WRITE of idx $40, then restart from $0200.
    start_dma(8'h02, 1'b0);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk); #1;
        if (dma_write && exp_q.size() == 191) begin
          found = 1;
          break;
        end
      end
      check("t4_reached_idx40", {31'd0, found}, 32'd1);
    end
    rst = 1'b1;
    abort_pending = 1;
    exp_q.delete();
    rd_q.delete();
    len_q.delete();
    @(posedge clk); #1;
    check("t4_reset_ctrl", {28'd0, stall, dma_active, dma_read, dma_write}, 32'd0);
    check("t4_reset_addr", {16'd0, dma_addr}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    start_dma(8'h02, 1'b0);
    wait_done("t4_restart");

    // Page $FF stays inside $FF00..$FFFF.
    start_dma(8'hFF, 1'b0);
    wait_done("t5_pageff");

    // Writes to other addresses and reads of the trigger address do nothing.
    cpu_cycle(16'h4015, 8'h07, 1'b1);
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        seen = seen | stall | dma_active;
      end
      check("t6_no_transfer", {31'd0, seen}, 32'd0);
    end

    check("final_queues_empty", exp_q.size() + rd_q.size() + len_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
